// File: rtl/cpu24_control_fsm.sv
`timescale 1ns/1ps
// cpu24_control_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the 24-bit CPU.
// Define CPU24_CTRL_PERF_EN to build the cycle_count/retire_count performance counters.
module cpu24_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        run,
    input  logic [3:0]  opcode,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        ALUSrc,
    output logic [1:0]  ALUOp,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal,
    output logic        bus_error,
    output logic [23:0] cycle_count,
    output logic [23:0] retire_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q;
    logic [3:0] op_q;
    logic [7:0] wait_q;
    logic       bus_error_q;

    // Zero only steers the branch target inside the datapath; the sequencer never needs it.
    logic unused_zero;
    assign unused_zero = Zero;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_HALT: op_legal = 1'b1;
            default:                                          op_legal = 1'b0;
        endcase
    endfunction

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_FETCH;
            op_q        <= '0;
            wait_q      <= '0;
            bus_error_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
            case (state_q)
                S_FETCH: begin
                    if (run) state_q <= S_DECODE;
                end
                S_DECODE: begin
                    op_q <= opcode;
                    if (opcode == OP_HALT)    state_q <= S_HALT;
                    else if (!op_legal(opcode)) state_q <= S_FETCH;
                    else                        state_q <= S_EXEC;
                end
                S_EXEC: begin
                    wait_q <= '0;
                    case (op_q)
                        OP_LW, OP_SW:       state_q <= S_MEM;
                        OP_RTYPE, OP_ADDI:  state_q <= S_WB;
                        default:            state_q <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (op_q != OP_LW && op_q != OP_SW) begin
                        state_q <= S_FETCH;
                    end else if (mem_ready) begin
                        state_q <= (op_q == OP_LW) ? S_WB : S_FETCH;
                    end else if (wait_q == WAIT_LAST) begin
                        // Ready on the final wait cycle takes the branch above, so it beats the timeout.
                        bus_error_q <= 1'b1;
                        state_q     <= S_HALT;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                S_WB:    state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output is defaulted first so no path through the case infers a latch.
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        Branch   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = ALU_ADD;
        halted   = 1'b0;
        illegal  = 1'b0;
        if (!Reset) begin
            case (state_q)
                S_FETCH: IRWrite = run;
                S_DECODE: begin
                    if (!op_legal(opcode)) begin
                        PCWrite = 1'b1;
                        illegal = 1'b1;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_RTYPE: begin
                            RegDst = 1'b1;
                            ALUOp  = ALU_FUNCT;
                        end
                        OP_ADDI, OP_LW, OP_SW: ALUSrc = 1'b1;
                        OP_BEQ: begin
                            ALUOp   = ALU_SUB;
                            Branch  = 1'b1;
                            PCWrite = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (op_q == OP_LW) begin
                        MemRead = 1'b1;
                        ALUSrc  = 1'b1;
                    end else if (op_q == OP_SW) begin
                        MemWrite = 1'b1;
                        ALUSrc   = 1'b1;
                        PCWrite  = mem_ready;
                    end
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                    case (op_q)
                        OP_RTYPE: begin
                            RegDst = 1'b1;
                            ALUOp  = ALU_FUNCT;
                        end
                        OP_ADDI: ALUSrc = 1'b1;
                        OP_LW: begin
                            MemToReg = 1'b1;
                            ALUSrc   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign state     = state_q;
    assign bus_error = bus_error_q;

`ifdef CPU24_CTRL_PERF_EN
    logic [23:0] cycle_q;
    logic [23:0] retire_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cycle_q  <= '0;
            retire_q <= '0;
        end else begin
            cycle_q <= cycle_q + 24'd1;
            if (PCWrite) retire_q <= retire_q + 24'd1;
        end
    end

    assign cycle_count  = cycle_q;
    assign retire_count = retire_q;
`else
    assign cycle_count  = '0;
    assign retire_count = '0;
`endif

endmodule

// File: tb/tb_cpu24_control_fsm.sv
`timescale 1ns/1ps
// tb_cpu24_control_fsm: per-cycle stimulus and expected controls are queued together,
// then popped and compared on the falling edge while the DUT steps through each instruction.
module tb_cpu24_control_fsm;

    localparam int unsigned TIMEOUT = 8;

    // Control bus layout: {PCWrite, IRWrite, RegDst, Branch, MemRead, MemWrite, RegWrite,
    // MemToReg, ALUSrc, ALUOp[1:0], halted, illegal}
    localparam logic [12:0] NONE    = 13'h0000;
    localparam logic [12:0] PCW     = 13'h1000;
    localparam logic [12:0] IRW     = 13'h0800;
    localparam logic [12:0] RDST    = 13'h0400;
    localparam logic [12:0] BR      = 13'h0200;
    localparam logic [12:0] MRD     = 13'h0100;
    localparam logic [12:0] MWR     = 13'h0080;
    localparam logic [12:0] RGW     = 13'h0040;
    localparam logic [12:0] M2R     = 13'h0020;
    localparam logic [12:0] ASRC    = 13'h0010;
    localparam logic [12:0] AOP_FN  = 13'h0008;
    localparam logic [12:0] AOP_SUB = 13'h0004;
    localparam logic [12:0] HLT     = 13'h0002;
    localparam logic [12:0] ILL     = 13'h0001;

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LW   = 4'h2;
    localparam logic [3:0] OP_SW   = 4'h3;
    localparam logic [3:0] OP_BEQ  = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] JUNK    = 4'hA;

    localparam logic [2:0] ST_F = 3'd0;
    localparam logic [2:0] ST_D = 3'd1;
    localparam logic [2:0] ST_E = 3'd2;
    localparam logic [2:0] ST_M = 3'd3;
    localparam logic [2:0] ST_W = 3'd4;
    localparam logic [2:0] ST_H = 3'd5;

    typedef struct {
        logic        run;
        logic [3:0]  opc;
        logic        zero;
        logic        rdy;
        logic [2:0]  st;
        logic [12:0] ctrl;
        logic        berr;
    } vec_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        run = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic        Zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        PCWrite, IRWrite, RegDst, Branch, MemRead, MemWrite;
    logic        RegWrite, MemToReg, ALUSrc;
    logic [1:0]  ALUOp;
    logic [2:0]  state;
    logic        halted, illegal, bus_error;
    logic [23:0] cycle_count, retire_count;
    logic [12:0] ctrl_bus;

    vec_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic        berr_exp = 1'b0;
    logic [23:0] exp_cycles = '0;
    logic [23:0] exp_retire = '0;

    always #5 Clock = ~Clock;

    assign ctrl_bus = {PCWrite, IRWrite, RegDst, Branch, MemRead, MemWrite, RegWrite,
                       MemToReg, ALUSrc, ALUOp, halted, illegal};

    cpu24_control_fsm #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .run          (run),
        .opcode       (opcode),
        .Zero         (Zero),
        .mem_ready    (mem_ready),
        .PCWrite      (PCWrite),
        .IRWrite      (IRWrite),
        .RegDst       (RegDst),
        .Branch       (Branch),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .RegWrite     (RegWrite),
        .MemToReg     (MemToReg),
        .ALUSrc       (ALUSrc),
        .ALUOp        (ALUOp),
        .state        (state),
        .halted       (halted),
        .illegal      (illegal),
        .bus_error    (bus_error),
        .cycle_count  (cycle_count),
        .retire_count (retire_count)
    );

    task automatic push(input logic r, input logic [3:0] o, input logic z, input logic rd,
                        input logic [2:0] s, input logic [12:0] c);
        vec_t v;
        v.run  = r;
        v.opc  = o;
        v.zero = z;
        v.rdy  = rd;
        v.st   = s;
        v.ctrl = c;
        v.berr = berr_exp;
        sb.push_back(v);
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic drain(input string name);
        vec_t        v;
        int          idx;
        logic [23:0] cc_exp, rc_exp;
        idx = 0;
        while (sb.size() > 0) begin
            v = sb.pop_front();
            run       = v.run;
            opcode    = v.opc;
            Zero      = v.zero;
            mem_ready = v.rdy;
            @(negedge Clock);
            vectors++;
            if (state !== v.st || ctrl_bus !== v.ctrl || bus_error !== v.berr) begin
                miscompares++;
                $display("FAIL %s[%0d]: state=%0d ctrl=%h berr=%b, expected state=%0d ctrl=%h berr=%b",
                         name, idx, state, ctrl_bus, bus_error, v.st, v.ctrl, v.berr);
            end
`ifdef CPU24_CTRL_PERF_EN
            cc_exp = exp_cycles;
            rc_exp = exp_retire;
`else
            cc_exp = '0;
            rc_exp = '0;
`endif
            vectors++;
            if (cycle_count !== cc_exp || retire_count !== rc_exp) begin
                miscompares++;
                $display("FAIL %s[%0d] counters: cycle=%0d retire=%0d, expected cycle=%0d retire=%0d",
                         name, idx, cycle_count, retire_count, cc_exp, rc_exp);
            end
            if ((v.ctrl & PCW) != 13'h0) exp_retire = exp_retire + 24'd1;
            exp_cycles = exp_cycles + 24'd1;
            idx++;
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        vectors++;
        if (state !== ST_F || ctrl_bus !== NONE || bus_error !== 1'b0 ||
            cycle_count !== 24'd0 || retire_count !== 24'd0) begin
            miscompares++;
            $display("FAIL %s: state=%0d ctrl=%h berr=%b cycle=%0d retire=%0d, expected all zero",
                     name, state, ctrl_bus, bus_error, cycle_count, retire_count);
        end
    endtask

    // Asserts Reset with run high, checks the forced-zero outputs, releases after one edge.
    task automatic apply_reset(input string name);
        run    = 1'b1;
        Reset  = 1'b1;
        #1;
        check_reset_outputs(name);
        @(posedge Clock);
        #1;
        check_reset_outputs({name, "_held"});
        Reset      = 1'b0;
        berr_exp   = 1'b0;
        exp_cycles = '0;
        exp_retire = '0;
    endtask

    task automatic test_reset();
        run = 1'b1;
        #1;
        check_reset_outputs("reset_initial");
        @(posedge Clock);
        @(posedge Clock);
        #1;
        check_reset_outputs("reset_held");
        Reset = 1'b0;
    endtask

    task automatic test_rtype();
        push(1, OP_R, 0, 0, ST_F, IRW);
        push(1, OP_R, 0, 0, ST_D, NONE);
        push(0, JUNK, 0, 1, ST_E, RDST | AOP_FN);
        push(0, JUNK, 0, 1, ST_W, RGW | PCW | RDST | AOP_FN);
        push(0, JUNK, 0, 0, ST_F, NONE);
        push(0, JUNK, 0, 0, ST_F, NONE);
        drain("rtype");
    endtask

    task automatic test_addi();
        push(1, OP_ADDI, 0, 0, ST_F, IRW);
        push(0, OP_ADDI, 0, 0, ST_D, NONE);
        push(0, JUNK,    0, 0, ST_E, ASRC);
        push(0, JUNK,    0, 0, ST_W, RGW | PCW | ASRC);
        push(0, JUNK,    0, 0, ST_F, NONE);
        drain("addi_run_drop");
    endtask

    task automatic test_lw_wait();
        push(1, OP_LW, 0, 0, ST_F, IRW);
        push(1, OP_LW, 0, 0, ST_D, NONE);
        push(1, JUNK,  0, 1, ST_E, ASRC);
        push(1, JUNK,  0, 0, ST_M, MRD | ASRC);
        push(1, JUNK,  0, 0, ST_M, MRD | ASRC);
        push(1, JUNK,  0, 1, ST_M, MRD | ASRC);
        push(0, JUNK,  0, 0, ST_W, RGW | PCW | M2R | ASRC);
        push(0, JUNK,  0, 0, ST_F, NONE);
        drain("lw_wait2");
    endtask

    task automatic test_sw_ready();
        push(1, OP_SW, 0, 0, ST_F, IRW);
        push(1, OP_SW, 0, 0, ST_D, NONE);
        push(0, JUNK,  0, 0, ST_E, ASRC);
        push(0, JUNK,  0, 1, ST_M, MWR | ASRC | PCW);
        push(0, JUNK,  0, 0, ST_F, NONE);
        drain("sw_ready");
    endtask

    task automatic test_illegal();
        logic [3:0] ops [3];
        ops[0] = 4'h7;
        ops[1] = 4'h5;
        ops[2] = 4'hE;
        for (int i = 0; i < 3; i++) begin
            push(1, ops[i], 0, 0, ST_F, IRW);
            push(0, ops[i], 0, 0, ST_D, PCW | ILL);
            push(0, ops[i], 0, 0, ST_F, NONE);
        end
        drain("illegal");
    endtask

    task automatic test_beq();
        push(1, OP_BEQ, 1, 0, ST_F, IRW);
        push(1, OP_BEQ, 1, 0, ST_D, NONE);
        push(0, JUNK,   1, 0, ST_E, BR | PCW | AOP_SUB);
        push(0, JUNK,   1, 0, ST_F, NONE);
        push(0, OP_BEQ, 1, 0, ST_F, NONE);
        drain("beq");
    endtask

    task automatic test_back_to_back();
        push(1, OP_ADDI, 0, 0, ST_F, IRW);
        push(1, OP_ADDI, 0, 0, ST_D, NONE);
        push(1, OP_ADDI, 0, 0, ST_E, ASRC);
        push(1, OP_ADDI, 0, 0, ST_W, RGW | PCW | ASRC);
        push(1, OP_LW,   0, 0, ST_F, IRW);
        push(1, OP_LW,   0, 0, ST_D, NONE);
        push(1, OP_LW,   0, 0, ST_E, ASRC);
        push(1, OP_LW,   0, 1, ST_M, MRD | ASRC);
        push(1, OP_LW,   0, 0, ST_W, RGW | PCW | M2R | ASRC);
        push(1, OP_BEQ,  0, 0, ST_F, IRW);
        push(1, OP_BEQ,  0, 0, ST_D, NONE);
        push(1, OP_BEQ,  0, 0, ST_E, BR | PCW | AOP_SUB);
        push(0, OP_BEQ,  0, 0, ST_F, NONE);
        drain("back_to_back");
    endtask

    task automatic test_ready_at_timeout();
        push(1, OP_SW, 0, 0, ST_F, IRW);
        push(1, OP_SW, 0, 0, ST_D, NONE);
        push(0, JUNK,  0, 0, ST_E, ASRC);
        for (int i = 0; i < int'(TIMEOUT) - 1; i++) push(0, JUNK, 0, 0, ST_M, MWR | ASRC);
        push(0, JUNK,  0, 1, ST_M, MWR | ASRC | PCW);
        push(0, JUNK,  0, 0, ST_F, NONE);
        drain("ready_at_timeout");
    endtask

    task automatic test_timeout();
        push(1, OP_SW, 0, 0, ST_F, IRW);
        push(1, OP_SW, 0, 0, ST_D, NONE);
        push(0, JUNK,  0, 0, ST_E, ASRC);
        for (int i = 0; i < int'(TIMEOUT); i++) push(0, JUNK, 0, 0, ST_M, MWR | ASRC);
        berr_exp = 1'b1;
        for (int i = 0; i < 3; i++) push(1, OP_R, 0, 1, ST_H, HLT);
        drain("sw_timeout");
        apply_reset("reset_after_timeout");
    endtask

    task automatic test_reset_mid_mem();
        push(1, OP_LW, 0, 0, ST_F, IRW);
        push(1, OP_LW, 0, 0, ST_D, NONE);
        push(0, JUNK,  0, 0, ST_E, ASRC);
        push(0, JUNK,  0, 0, ST_M, MRD | ASRC);
        push(0, JUNK,  0, 0, ST_M, MRD | ASRC);
        drain("lw_before_reset");
        run       = 1'b0;
        opcode    = JUNK;
        mem_ready = 1'b0;
        #2;
        vectors++;
        if (state !== ST_M || ctrl_bus !== (MRD | ASRC)) begin
            miscompares++;
            $display("FAIL lw_mid_mem: state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                     state, ctrl_bus, ST_M, MRD | ASRC);
        end
        // Reset lands mid-cycle, away from any clock edge.
        apply_reset("reset_mid_mem");
    endtask

    task automatic test_halt_opcode();
        push(1, OP_HALT, 0, 0, ST_F, IRW);
        push(1, OP_HALT, 0, 0, ST_D, NONE);
        push(1, OP_R,    0, 1, ST_H, HLT);
        push(1, OP_R,    0, 1, ST_H, HLT);
        drain("halt_opcode");
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_addi();
        test_lw_wait();
        test_sw_ready();
        test_illegal();
        test_beq();
        test_back_to_back();
        test_ready_at_timeout();
        test_timeout();
        test_rtype();
        test_reset_mid_mem();
        test_rtype();
        test_halt_opcode();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
